// File: rtl/pipe_hazard_unit_if.sv
// Decode-side hazard bus: decode operands in, stall/flush/forward control out.
// Latency: none of its own; it only carries signals.
// Backpressure: the stall outputs hold fetch/decode, and flush squashes them.
interface pipe_hazard_unit_if #(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
);
    // Decode stage instruction description
    logic              valid_id;
    logic [REG_AW-1:0] RS1_id;
    logic [REG_AW-1:0] RS2_id;
    logic              use_rs1_id;
    logic              use_rs2_id;
    logic [REG_AW-1:0] RD_id;
    logic              RW_id;
    logic              MD_id;
    // Branch resolution from EX
    logic              br_taken_ex;
    // Control returned to fetch/decode/execute
    logic              stall_if;
    logic              stall_id;
    logic              flush_if;
    logic              bubble_ex;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output valid_id, RS1_id, RS2_id, use_rs1_id, use_rs2_id,
               RD_id, RW_id, MD_id, br_taken_ex,
        input  stall_if, stall_id, flush_if, bubble_ex,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  valid_id, RS1_id, RS2_id, use_rs1_id, use_rs2_id,
               RD_id, RW_id, MD_id, br_taken_ex,
        output stall_if, stall_id, flush_if, bubble_ex,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard unit: tracks in-flight writes (EX/MEM/WB), raises load-use stall, branch flush, forwarding selects.
// Latency: stall/flush/bubble are combinational; fwd selects are registered to line up with EX.
// Backpressure: load-use holds PC and IF/ID for one cycle; a taken branch overrides it with a flush.
module pipe_hazard_unit #(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    pipe_hazard_unit_if.slave hz
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } trk_t;

    trk_t t1_q, t2_q, t3_q;
    trk_t new_d;

    logic             lu;
    logic             flush;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // A source hits a tracker entry only if it is actually read
    function automatic logic hit(input trk_t t, input logic [REG_AW-1:0] s, input logic use_s);
        return t.v && (t.rd == s) && use_s;
    endfunction

    // Youngest producer wins; a load still in EX cannot supply data, so it is skipped
    function automatic logic [1:0] fwd_sel(input trk_t a, input trk_t b, input trk_t c,
                                           input logic [REG_AW-1:0] s, input logic use_s);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_s && (s != '0)) begin
            if (hit(a, s, use_s) && !a.ld) begin
                sel = 2'b01;
            end else if (hit(b, s, use_s)) begin
                sel = 2'b10;
            end else if (hit(c, s, use_s)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    // Hazard detection, tracker entry and next-state for selects and counters
    always_comb begin
        flush = hz.br_taken_ex;
        lu    = hz.valid_id && !hz.br_taken_ex && t1_q.ld &&
                (hit(t1_q, hz.RS1_id, hz.use_rs1_id) || hit(t1_q, hz.RS2_id, hz.use_rs2_id));

        new_d = '0;
        if (hz.valid_id && !lu && !flush) begin
            new_d.v  = hz.RW_id && (hz.RD_id != '0);
            new_d.rd = hz.RD_id;
            new_d.ld = hz.MD_id;
        end

        fwd_a_d = fwd_sel(t1_q, t2_q, t3_q, hz.RS1_id, hz.use_rs1_id);
        fwd_b_d = fwd_sel(t1_q, t2_q, t3_q, hz.RS2_id, hz.use_rs2_id);
        if (lu || flush) begin
            fwd_a_d = 2'b00;
            fwd_b_d = 2'b00;
        end

        stall_cnt_d = stall_cnt_q;
        if (lu && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Tracker shift, registered forwarding selects and event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t1_q        <= '0;
            t2_q        <= '0;
            t3_q        <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            t3_q        <= t2_q;
            t2_q        <= t1_q;
            t1_q        <= new_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_if  = lu;
    assign hz.stall_id  = lu;
    assign hz.bubble_ex = lu || flush;
    assign hz.flush_if  = flush;
    assign hz.fwd_a     = fwd_a_q;
    assign hz.fwd_b     = fwd_b_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule
